// File: rtl/mesi_isc_broad_fifo.sv
// Broadcast request FIFO between the broadcast arbiter and broadcast control.
// Show-ahead head outputs, registered status flags, sticky overflow/underflow.
module mesi_isc_broad_fifo #(
   parameter int FIFO_SIZE      = 4,
   parameter int FIFO_SIZE_LOG2 = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_i,
   input  logic [31:0] addr_i,
   input  logic [1:0]  type_i,
   input  logic [1:0]  cpu_id_i,
   input  logic [6:0]  id_i,
   input  logic        rd_i,
   output logic [31:0] addr_o,
   output logic [1:0]  type_o,
   output logic [1:0]  cpu_id_o,
   output logic [6:0]  id_o,
   output logic        status_empty_o,
   output logic        status_full_o,
   output logic        overflow_o,
   output logic        underflow_o
);

   localparam int ENTRY_W = 43;
   localparam logic [FIFO_SIZE_LOG2:0] FULL_CNT = FIFO_SIZE[FIFO_SIZE_LOG2:0];
   localparam logic [FIFO_SIZE_LOG2:0] ONE_CNT  = {{FIFO_SIZE_LOG2{1'b0}}, 1'b1};
   localparam logic [FIFO_SIZE_LOG2-1:0] ONE_PTR = {{(FIFO_SIZE_LOG2-1){1'b0}}, 1'b1};

   logic [ENTRY_W-1:0]        mem [FIFO_SIZE];
   logic [FIFO_SIZE_LOG2-1:0] wr_ptr;
   logic [FIFO_SIZE_LOG2-1:0] rd_ptr;
   logic [FIFO_SIZE_LOG2:0]   count;
   logic [FIFO_SIZE_LOG2:0]   count_next;
   logic                      wr_ok;
   logic                      rd_ok;

   // Acceptance uses the registered flags, so full+rd+wr pops only and empty+rd+wr pushes only.
   assign wr_ok = wr_i & ~status_full_o;
   assign rd_ok = rd_i & ~status_empty_o;

   always_comb begin
      count_next = count;
      if (wr_ok && !rd_ok)
         count_next = count + ONE_CNT;
      else if (rd_ok && !wr_ok)
         count_next = count - ONE_CNT;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         status_empty_o <= 1'b1;
         status_full_o  <= 1'b0;
         overflow_o     <= 1'b0;
         underflow_o    <= 1'b0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + ONE_PTR;
         if (rd_ok)
            rd_ptr <= rd_ptr + ONE_PTR;
         count          <= count_next;
         status_empty_o <= (count_next == '0);
         status_full_o  <= (count_next == FULL_CNT);
         if (wr_i && status_full_o)
            overflow_o <= 1'b1;
         if (rd_i && status_empty_o)
            underflow_o <= 1'b1;
      end
   end

   // Storage is deliberately left out of reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (wr_ok && !rst)
         mem[wr_ptr] <= {addr_i, type_i, cpu_id_i, id_i};
   end

   assign {addr_o, type_o, cpu_id_o, id_o} = mem[rd_ptr];

endmodule

// File: doc/mesi_isc_broad_fifo.md
# mesi_isc_broad_fifo

Broadcast request FIFO of the MESI intersection controller, directly downstream of the broadcast request arbiter. It captures each granted broadcast (address, type, originating CPU, transaction id) when the arbiter pulses its write strobe. It holds the entries in order for the broadcast control stage. It reports fullness back to the arbiter, which withholds further grants while the FIFO is full.

## Interface
Parameters:
- FIFO_SIZE, 4: number of entries; power of two, minimum 2.
- FIFO_SIZE_LOG2, 2: log2(FIFO_SIZE); pointer width.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- wr_i  input  1  write strobe; driven by the arbiter's broad_fifo_wr.
- addr_i  input  32  broadcast address (arbiter broad_addr).
- type_i  input  2  broadcast type (arbiter broad_type).
- cpu_id_i  input  2  originating CPU (arbiter broad_cpu_id).
- id_i  input  7  broadcast transaction id (arbiter broad_id).
- rd_i  input  1  pop strobe from the broadcast control stage.
- addr_o  output  32  head entry address.
- type_o  output  2  head entry type.
- cpu_id_o  output  2  head entry CPU id.
- id_o  output  7  head entry transaction id.
- status_empty_o  output  1  no valid entry; head outputs are don't-care.
- status_full_o  output  1  FIFO_SIZE entries held; drives the arbiter's broad_fifo_status_full.
- overflow_o  output  1  sticky flag: a write was attempted while full.
- underflow_o  output  1  sticky flag: a read was attempted while empty.

## Operation
- Storage:
  - FIFO_SIZE x 43-bit entries, packed {addr, type, cpu_id, id}.
  - Write pointer, read pointer and entry count are registered. Count is FIFO_SIZE_LOG2+1 bits, range 0..FIFO_SIZE.
- Write acceptance:
  - A write is accepted when wr_i=1 and status_full_o=0 (registered value at that edge).
  - An accepted write stores the inputs at the write pointer and increments the pointer modulo FIFO_SIZE.
- Read acceptance:
  - A read is accepted when rd_i=1 and status_empty_o=0.
  - An accepted read increments the read pointer modulo FIFO_SIZE.
- Count update per edge:
  - write only: +1.
  - read only: -1.
  - both or neither: unchanged.
- Show-ahead output: the head outputs are always the entry at the read pointer, read combinationally from storage. No read latency.
- Status flags are registered:
  - status_empty_o = (next count == 0).
  - status_full_o = (next count == FIFO_SIZE).
- Simultaneous events:
  - Full with rd_i=1 and wr_i=1: the read is accepted and the write is rejected; overflow_o sets. Full is evaluated on registered state, and the arbiter never writes while it sees full.
  - Empty with rd_i=1 and wr_i=1: the write is accepted and the read is rejected; underflow_o sets. Count becomes 1.
  - Partially filled with both strobes: both are accepted, count is unchanged, and both pointers advance.
- Pointers wrap from FIFO_SIZE-1 to 0 with no gap or bubble.
- Error flags:
  - overflow_o and underflow_o are sticky; only rst clears them.
  - A rejected access changes no storage, pointer or count.

## Timing
- Reset (rst=1 at an edge) sets the following, regardless of wr_i/rd_i in the same cycle:
  - pointers = 0, count = 0.
  - status_empty_o = 1, status_full_o = 0.
  - overflow_o = 0, underflow_o = 0.
- Storage contents are not reset. Head outputs are don't-care while empty.
- Reset mid-operation discards all entries. The first cycle after reset accepts writes normally.
- Write-to-visible latency is 1 cycle:
  - A write accepted at edge N appears on the head outputs after edge N (if it is the head).
  - status_empty_o falls after the same edge N.
- Full feedback latency is 1 cycle: status_full_o rises after the edge that stores the FIFO_SIZE-th entry. The arbiter samples it the following cycle.
- Read: the head outputs and status flags reflect the pop after edge N. Sustained one read plus one write per cycle is supported indefinitely.

## Test plan
- Reset and single entry:
  - Stimulus: assert rst; then write addr=0x0000_1A40, type=2, cpu=3, id=0x05.
  - Required: empty=1 and full=0 after reset. Next cycle empty=0 and the head outputs show exactly those values. Pop with rd_i -> empty=1.
- Fill to full and overflow:
  - Stimulus: write 4 entries with ids 1..4; then a 5th write with id 9.
  - Required: full=1 after the 4th write. The 5th write is rejected and overflow_o=1. Popping 4 times yields ids 1,2,3,4 in order, then empty=1.
- Underflow:
  - Stimulus: rd_i=1 while empty.
  - Required: underflow_o=1 and stays 1. Pointers unchanged: a following write of id 7 is the head.
- Pointer wrap with concurrent read/write:
  - Stimulus: hold 2 entries; assert rd_i=wr_i=1 for 10 cycles with ids 10..19.
  - Required: count stays 2 and full/empty never assert. Heads appear in strict FIFO order across the wrap.
- Simultaneous events at the boundaries:
  - Full with rd+wr: count becomes 3 and overflow_o=1.
  - Empty with rd+wr: count becomes 1, underflow_o=1, and the head equals the written entry.
- Reset mid-operation:
  - Stimulus: hold 3 entries; assert rst together with wr_i=1.
  - Required: empty=1, count 0 and both flags 0 next cycle. The concurrent write is discarded.
